// File: rtl/spi_adc_scanner.sv
// rtl/spi_adc_scanner.sv - multi-channel SPI controller for MCP3208-class ADCs with per-channel result bank
//
// Scans channels 0..NUM_CH-1 (mode=0) or converts one clamped channel sel_ch (mode=1).
// Conversions can be single-ended or differential. The latest result for each channel is kept in a bank.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   enable           run frames back to back while high
//   mode, sel_ch     0 = scan, 1 = single channel sel_ch (clamped to NUM_CH-1)
//   diff             1 = differential conversion (SGL/DIFF command bit sent as 0)
//   MISO/MOSI/SCK/CS SPI pins: SPI mode 0, CS active-low
//   busy             high whenever the FSM is not idle
//   data_valid       one-cycle strobe; data/data_ch carry the new result
//   rd_ch, rd_data   combinational bank read port (0 for rd_ch >= NUM_CH)
//
// Optional build macro SPI_AVG_EN:
//   Each channel averages 2^AVG_LOG2 frames before it updates the bank and strobes.
`timescale 1ns/1ps
module spi_adc_scanner #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 12,
    parameter int CLK_DIV  = 4,
    parameter int CS_GAP   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mode,
    input  logic [2:0]        sel_ch,
    input  logic              diff,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SCK,
    output logic              CS,
    output logic              busy,
    output logic              data_valid,
    output logic [2:0]        data_ch,
    output logic [DATA_W-1:0] data,
    input  logic [2:0]        rd_ch,
    output logic [DATA_W-1:0] rd_data
);

    // Frame bits: 5 command bits, a sample bit, a null bit, then DATA_W data bits.
    localparam int NBITS   = DATA_W + 7;
    localparam int BIT_W   = $clog2(NBITS + 1);
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NBITS - 1);
    localparam logic [BIT_W-1:0] BIT_DATA0 = BIT_W'(7);
    localparam logic [2:0]       CH_LAST   = 3'(NUM_CH - 1);

    if (NUM_CH < 1 || NUM_CH > 8 || DATA_W < 2 || CLK_DIV < 2 || CS_GAP < 1 || AVG_LOG2 < 1) begin : g_bad_params
        $error("spi_adc_scanner: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               phase_q, phase_d;   // 1 = SCK high half of the current bit

    logic               latch;              // capture mode/diff/channel for a new frame
    logic               sample;             // shift MISO into the data word
    logic               frame_done;         // HOLD exit

    logic               mode_q, diff_q;
    logic [2:0]         ch_q, scan_q, next_ch;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  bank_q [8];
    logic [DATA_W-1:0]  data_q;
    logic [2:0]         data_ch_q;
    logic               data_valid_q;

    logic               commit;             // this frame publishes a result
    logic [DATA_W-1:0]  result;
    logic [BIT_W-1:0]   mosi_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
        end
    end

    // SETUP is the low half ahead of bit 0. In SHIFT, each bit is a high half and then a low half.
    // During that low half MOSI already shows the next bit.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        phase_d    = phase_q;
        latch      = 1'b0;
        sample     = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    latch   = 1'b1;
                    state_d = S_SETUP;
                    div_d   = '0;
                end
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b1;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                // Sample in the first clk cycle of the SCK high half.
                sample = phase_q && (div_q == '0) && (bit_q >= BIT_DATA0);
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (phase_q) begin
                        phase_d = 1'b0;
                    end else if (bit_q == BIT_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        phase_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (div_q == DIV_LAST) begin
                    frame_done = 1'b1;
                    state_d    = S_GAP;
                    div_d      = '0;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d = '0;
                    if (enable) begin
                        latch   = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (mode) begin
            next_ch = (int'(sel_ch) >= NUM_CH) ? CH_LAST : sel_ch;
        end else begin
            next_ch = scan_q;
        end
    end

`ifdef SPI_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q [8];
    logic [AVG_LOG2-1:0] cnt_q [8];
    logic [ACC_W-1:0]    acc_sum;
    logic                avg_clear;

    always_comb begin
        acc_sum   = acc_q[ch_q] + ACC_W'(shift_q);
        commit    = (cnt_q[ch_q] == '1);
        result    = acc_sum[ACC_W-1:AVG_LOG2];
        avg_clear = latch && ((mode != mode_q) || (diff != diff_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (avg_clear) begin
            for (int i = 0; i < 8; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (frame_done) begin
            if (commit) begin
                acc_q[ch_q] <= '0;
                cnt_q[ch_q] <= '0;
            end else begin
                acc_q[ch_q] <= acc_sum;
                cnt_q[ch_q] <= cnt_q[ch_q] + AVG_LOG2'(1);
            end
        end
    end
`else
    always_comb begin
        commit = 1'b1;
        result = shift_q;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q       <= 1'b0;
            diff_q       <= 1'b0;
            ch_q         <= '0;
            scan_q       <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_ch_q    <= '0;
            data_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            data_valid_q <= 1'b0;
            if (latch) begin
                mode_q  <= mode;
                diff_q  <= diff;
                ch_q    <= next_ch;
                shift_q <= '0;
            end
            if (sample) begin
                shift_q <= {shift_q[DATA_W-2:0], MISO};
            end
            if (frame_done) begin
                if (!mode_q) begin
                    scan_q <= (ch_q >= CH_LAST) ? 3'd0 : ch_q + 3'd1;
                end
                if (commit) begin
                    bank_q[ch_q] <= result;
                    data_q       <= result;
                    data_ch_q    <= ch_q;
                    data_valid_q <= 1'b1;
                end
            end
        end
    end

    // Command bits b0..b4 = start, SGL/DIFF, D2, D1, D0. All later bits are 0.
    always_comb begin
        MOSI     = 1'b0;
        mosi_idx = phase_q ? bit_q : bit_q + BIT_W'(1);
        if (state_q == S_SETUP) begin
            MOSI = 1'b1;
        end else if (state_q == S_SHIFT) begin
            case (mosi_idx)
                BIT_W'(0): MOSI = 1'b1;
                BIT_W'(1): MOSI = ~diff_q;
                BIT_W'(2): MOSI = ch_q[2];
                BIT_W'(3): MOSI = ch_q[1];
                BIT_W'(4): MOSI = ch_q[0];
                default:   MOSI = 1'b0;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_ch) < NUM_CH) begin
            rd_data = bank_q[rd_ch];
        end
    end

    assign CS         = !((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD));
    assign SCK        = (state_q == S_SHIFT) && phase_q;
    assign busy       = (state_q != S_IDLE);
    assign data_valid = data_valid_q;
    assign data_ch    = data_ch_q;
    assign data       = data_q;

endmodule

// File: tb/tb_spi_adc_scanner.sv
// tb/tb_spi_adc_scanner.sv - self-checking bench for spi_adc_scanner with an MCP3208-style ADC model
`timescale 1ns/1ps
module tb_spi_adc_scanner;

    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 12;
    localparam int CLK_DIV  = 4;
    localparam int CS_GAP   = 8;
    localparam int AVG_LOG2 = 2;
    localparam int CS_LOW   = 40 * CLK_DIV;
    localparam int FRAME    = CS_LOW + CS_GAP;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic              mode = 1'b0;
    logic [2:0]        sel_ch = 3'd0;
    logic              diff = 1'b0;
    logic              MISO = 1'b0;
    logic              MOSI, SCK, CS, busy, data_valid;
    logic [2:0]        data_ch;
    logic [DATA_W-1:0] data;
    logic [2:0]        rd_ch = 3'd0;
    logic [DATA_W-1:0] rd_data;

    spi_adc_scanner #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sel_ch(sel_ch), .diff(diff),
        .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .CS(CS), .busy(busy), .data_valid(data_valid),
        .data_ch(data_ch), .data(data), .rd_ch(rd_ch), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [2:0]        ch;
        logic [DATA_W-1:0] val;
        logic [4:0]        cmd;
    } exp_t;

    exp_t sb_q[$];

    // ADC model and scoreboard, both sampled on the falling clk edge.
    logic              sck_prev = 1'b0;
    logic              cs_prev = 1'b1;
    int                rise_cnt = 0;
    logic [4:0]        cmd_cap = '0;
    logic              mosi_tail = 1'b0;
    logic [DATA_W-1:0] cur_word = '0;
    logic [DATA_W-1:0] adc_val [8];
    logic [DATA_W-1:0] seq_q[$];
    int                cs_cnt = 0;
    int                last_cs_len = 0;
    int                frames_done = 0;
    int                valid_cnt = 0;
    longint            cyc = 0;
    longint            valid_cyc_q[$];
    logic              sck_bad = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (cs_prev && !CS) begin
            rise_cnt  = 0;
            cmd_cap   = '0;
            mosi_tail = 1'b0;
            MISO      = 1'b0;
            cs_cnt    = 0;
        end
        if (!CS) cs_cnt++;
        if (!cs_prev && CS) begin
            last_cs_len = cs_cnt;
            frames_done++;
        end
        if (SCK && CS) sck_bad = 1'b1;
        if (!CS && SCK && !sck_prev) begin
            if (rise_cnt < 5) cmd_cap[4-rise_cnt] = MOSI;
            else if (MOSI) mosi_tail = 1'b1;
            rise_cnt++;
            if (rise_cnt == 5) cur_word = (seq_q.size() > 0) ? seq_q.pop_front() : adc_val[cmd_cap[2:0]];
        end
        if (!CS && !SCK && sck_prev) begin
            MISO = (rise_cnt >= 7 && rise_cnt <= 18) ? cur_word[18-rise_cnt] : 1'b0;
        end
        if (data_valid) begin
            valid_cnt++;
            valid_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: strobe with data 0x%0h ch %0d, required no strobe", data, data_ch);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", data, e.val);
                check("sb_ch", data_ch, e.ch);
                check("sb_cmd", cmd_cap, e.cmd);
                check("sb_mosi_tail", mosi_tail, 0);
                check("sb_cs_low", last_cs_len, CS_LOW);
            end
        end
        sck_prev = SCK;
        cs_prev  = CS;
    end

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, lvl);
    endtask

    task automatic wait_valid(input int target, input int budget, input string name);
        int n = 0;
        while (valid_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (valid_cnt < target) begin
            fails++;
            $display("FAIL %s: strobes %0d, required %0d", name, valid_cnt, target);
        end
    endtask

    task automatic wait_rise(input int target, input int budget, input string name);
        int n = 0;
        while (rise_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (rise_cnt >= target), 1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_cs"}, CS, 1);
        check({name, "_sck"}, SCK, 0);
        check({name, "_mosi"}, MOSI, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_dv"}, data_valid, 0);
        check({name, "_data"}, data, 0);
        check({name, "_data_ch"}, data_ch, 0);
    endtask

    task automatic check_bank_zero(input string name);
        for (int r = 0; r < 8; r++) begin
            rd_ch = 3'(r);
            #1;
            check(name, rd_data, 0);
        end
    endtask

    typedef struct {
        logic              mode;
        logic [2:0]        sel;
        logic              diff;
        logic [DATA_W-1:0] val;
        logic [2:0]        ch;
        logic [4:0]        cmd;
    } vec_t;

    vec_t vt[5];

    initial begin
        int start;
        int fstart;
        int cs_low_seen;
        int vbase;

        for (int c = 0; c < 8; c++) adc_val[c] = '0;

        vt[0] = '{1'b1, 3'd3, 1'b0, 12'hA5C, 3'd3, 5'b11011};
        vt[1] = '{1'b1, 3'd7, 1'b0, 12'h3C7, 3'd3, 5'b11011};
        vt[2] = '{1'b1, 3'd1, 1'b1, 12'hFFF, 3'd1, 5'b10001};
        vt[3] = '{1'b1, 3'd0, 1'b0, 12'h000, 3'd0, 5'b11000};
        vt[4] = '{1'b1, 3'd2, 1'b1, 12'h800, 3'd2, 5'b10010};

        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check_bank_zero("reset_bank");

`ifndef SPI_AVG_EN
        // Single-channel frames, enable dropped as soon as the frame starts.
        for (int i = 0; i < 5; i++) begin
            mode   = vt[i].mode;
            sel_ch = vt[i].sel;
            diff   = vt[i].diff;
            adc_val[vt[i].ch] = vt[i].val;
            sb_q.push_back('{vt[i].ch, vt[i].val, vt[i].cmd});
            start  = valid_cnt;
            enable = 1'b1;
            wait_busy(1'b1, 20, "vec_start");
            enable = 1'b0;
            wait_valid(start + 1, FRAME + 50, "vec_strobe_timeout");
            wait_busy(1'b0, CS_GAP + 20, "vec_idle");
            repeat (20) @(negedge clk);
            check("vec_strobe_count", valid_cnt - start, 1);
            rd_ch = vt[i].ch;
            #1;
            check("vec_bank", rd_data, vt[i].val);
        end

        // Scan mode: channels 0..3 then wrap to 0, one frame period apart.
        mode = 1'b0;
        diff = 1'b0;
        for (int c = 0; c < NUM_CH; c++) adc_val[c] = 12'h100 + 12'(c);
        for (int k = 0; k < 5; k++) begin
            sb_q.push_back('{3'(k % NUM_CH), 12'h100 + 12'(k % NUM_CH), {2'b11, 3'(k % NUM_CH)}});
        end
        start  = valid_cnt;
        vbase  = valid_cyc_q.size();
        enable = 1'b1;
        wait_valid(start + 5, 5 * FRAME + 100, "scan_timeout");
        enable = 1'b0;
        wait_busy(1'b0, FRAME + 20, "scan_idle");
        repeat (20) @(negedge clk);
        check("scan_strobe_count", valid_cnt - start, 5);
        if (valid_cyc_q.size() >= vbase + 5) begin
            for (int k = 1; k < 5; k++) begin
                check("scan_spacing", valid_cyc_q[vbase+k] - valid_cyc_q[vbase+k-1], FRAME);
            end
        end
        for (int r = 0; r < 8; r++) begin
            rd_ch = 3'(r);
            #1;
            check("scan_bank", rd_data, (r < NUM_CH) ? 12'h100 + 12'(r) : 12'h000);
        end

        // enable dropped at bit 10: the frame still completes and stores.
        mode   = 1'b1;
        sel_ch = 3'd2;
        diff   = 1'b0;
        adc_val[2] = 12'h5A5;
        sb_q.push_back('{3'd2, 12'h5A5, 5'b11010});
        start  = valid_cnt;
        enable = 1'b1;
        wait_busy(1'b1, 20, "drop_start");
        repeat (2) @(negedge clk);
        wait_rise(11, FRAME, "drop_reach_b10");
        enable = 1'b0;
        wait_valid(start + 1, FRAME, "drop_strobe_timeout");
        wait_busy(1'b0, CS_GAP + 20, "drop_idle");
        cs_low_seen = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            if (!CS) cs_low_seen++;
        end
        check("drop_cs_stays_high", cs_low_seen, 0);
        check("drop_busy", busy, 0);
        check("drop_strobe_count", valid_cnt - start, 1);

        // Reset asserted at bit 10: immediate abort, nothing stored, bank cleared.
        sel_ch = 3'd1;
        adc_val[1] = 12'h777;
        start  = valid_cnt;
        enable = 1'b1;
        wait_busy(1'b1, 20, "rst_start");
        repeat (2) @(negedge clk);
        wait_rise(11, FRAME, "rst_reach_b10");
        reset = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (FRAME) @(negedge clk);
        check("rst_no_strobe", valid_cnt - start, 0);
        check_bank_zero("rst_bank");
`else
        // Averaging: four frames on channel 0, one strobe with the truncated mean.
        mode   = 1'b1;
        sel_ch = 3'd0;
        diff   = 1'b0;
        seq_q.push_back(12'h100);
        seq_q.push_back(12'h101);
        seq_q.push_back(12'h102);
        seq_q.push_back(12'h104);
        sb_q.push_back('{3'd0, 12'h101, 5'b11000});
        fstart = frames_done;
        start  = valid_cnt;
        enable = 1'b1;
        wait_valid(start + 1, 4 * FRAME + 100, "avg_timeout");
        check("avg_frames_before_strobe", frames_done - fstart, 4);
        enable = 1'b0;
        wait_busy(1'b0, FRAME + 20, "avg_idle");
        repeat (20) @(negedge clk);
        check("avg_strobe_count", valid_cnt - start, 1);
        rd_ch = 3'd0;
        #1;
        check("avg_bank", rd_data, 12'h101);
`endif

        check("sck_while_cs_high", sck_bad, 0);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
